// File: rtl/riscv_pkg.sv
// riscv_pkg: shared state encoding and RV32 R-type decode constants for the multicycle controller.
package riscv_pkg;
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_e;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [2:0] FN3_ADDSUB = 3'b000;
   localparam logic [2:0] FN3_AND    = 3'b111;
   localparam logic [2:0] FN3_OR     = 3'b110;
   localparam logic [6:0] FN7_BASE   = 7'b0000000;
   localparam logic [6:0] FN7_SUB    = 7'b0100000;
   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_SUB    = 2'b01;
   localparam logic [1:0] ALU_AND    = 2'b10;
   localparam logic [1:0] ALU_OR     = 2'b11;
endpackage

// File: rtl/riscv_rtype_decoder.sv
// riscv_rtype_decoder: combinational R-type decode of ADD/SUB/AND/OR into legality, ALU op and register fields.
module riscv_rtype_decoder
   import riscv_pkg::*;
(
   input  logic [31:0] ir,
   output logic        legal,
   output logic [1:0]  alu_op,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd
);
   logic [6:0] opc, fn7;
   logic [2:0] fn3;
   assign opc = ir[6:0];
   assign fn3 = ir[14:12];
   assign fn7 = ir[31:25];
   assign rd  = ir[11:7];
   assign rs1 = ir[19:15];
   assign rs2 = ir[24:20];
   assign legal = (opc == OPC_RTYPE) &&
                  (((fn3 == FN3_ADDSUB) && (fn7 == FN7_BASE || fn7 == FN7_SUB)) ||
                   ((fn7 == FN7_BASE) && (fn3 == FN3_AND || fn3 == FN3_OR)));
   assign alu_op = (fn3 == FN3_AND) ? ALU_AND :
                   (fn3 == FN3_OR)  ? ALU_OR  :
                   (fn7 == FN7_SUB) ? ALU_SUB : ALU_ADD;
endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: FETCH/DECODE/EXEC/WB sequencer owning the PC, IR, ALU op select and retire count.
module riscv_multicycle_ctrl
   import riscv_pkg::*;
#(
   parameter int PC_W  = 5,
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic             imem_ack,
   input  logic [XLEN-1:0]  imem_rdata,
   output logic [PC_W-1:0]  pc,
   output logic [XLEN-1:0]  ir,
   output logic [4:0]       rf_rs1,
   output logic [4:0]       rf_rs2,
   output logic [4:0]       rf_rd,
   output logic             rf_we,
   output logic [1:0]       alu_op,
   output logic             busy,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);
   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  ir_q, ir_d;
   logic [1:0]       alu_op_q, alu_op_d, dec_op;
   logic             illegal_q, illegal_d, dec_legal;
   logic [CNT_W-1:0] retired_q, retired_d;

   riscv_rtype_decoder u_dec (
      .ir     (ir_q[31:0]),
      .legal  (dec_legal),
      .alu_op (dec_op),
      .rs1    (rf_rs1),
      .rs2    (rf_rs2),
      .rd     (rf_rd)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         alu_op_q  <= ALU_ADD;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         alu_op_q  <= alu_op_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      alu_op_d  = alu_op_q;
      illegal_d = illegal_q;
      retired_d = retired_q;
      case (state_q)
         IDLE:    state_d = start ? FETCH : IDLE;
         FETCH: begin
            ir_d    = imem_ack ? imem_rdata : ir_q;
            state_d = imem_ack ? DECODE : FETCH;
         end
         DECODE: begin
            alu_op_d  = dec_legal ? dec_op : alu_op_q;
            illegal_d = illegal_q | ~dec_legal;
            state_d   = dec_legal ? EXEC : HALT;
         end
         EXEC:    state_d = WB;
         WB: begin
            pc_d      = pc_q + 1'b1;
            retired_d = retired_q + 1'b1;
            state_d   = start ? FETCH : IDLE;
         end
         default: state_d = HALT;
      endcase
   end

   assign imem_req  = (state_q == FETCH);
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   // x0 is hardwired zero, so its write is suppressed while the instruction still retires
   assign rf_we     = (state_q == WB) && (rf_rd != 5'd0);
   assign alu_op    = alu_op_q;
   assign busy      = (state_q != IDLE) && (state_q != HALT);
   assign halted    = (state_q == HALT);
   assign illegal   = illegal_q;
   assign retired   = retired_q;
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl: directed vectors for the multicycle controller with hand-computed expectations.
module tb_riscv_multicycle_ctrl;
   logic        clk, reset, start, imem_req, imem_ack, rf_we, busy, halted, illegal;
   logic [4:0]  imem_addr, pc, rf_rs1, rf_rs2, rf_rd;
   logic [31:0] imem_rdata, ir;
   logic [1:0]  alu_op;
   logic [15:0] retired;
   int checks = 0;
   int errors = 0;
   int exp_pc = 0;
   int exp_ret = 0;

   riscv_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .ir(ir), .rf_rs1(rf_rs1),
      .rf_rs2(rf_rs2), .rf_rd(rf_rd), .rf_we(rf_we), .alu_op(alu_op), .busy(busy),
      .halted(halted), .illegal(illegal), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"}, 32'(pc), 32'd0);
      chk({tag, "_ir"}, ir, 32'd0);
      chk({tag, "_req"}, 32'(imem_req), 32'd0);
      chk({tag, "_we"}, 32'(rf_we), 32'd0);
      chk({tag, "_op"}, 32'(alu_op), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_halt"}, 32'(halted), 32'd0);
      chk({tag, "_ill"}, 32'(illegal), 32'd0);
      chk({tag, "_ret"}, 32'(retired), 32'd0);
   endtask

   // Called at a negedge with the DUT in IDLE; executes one instruction and returns in IDLE (or HALT).
   task automatic run_instr(input logic [31:0] w, input int wt, input logic legal,
                            input logic [1:0] op, input logic we, input logic full);
      imem_rdata = w;
      imem_ack   = 1'b0;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < wt; i++) begin
         if (full) chk("fetch_wait_req", 32'(imem_req), 32'd1);
         if (full) chk("fetch_wait_ir", ir, 32'(exp_pc == 0 && exp_ret == 0 ? 32'd0 : ir));
         @(negedge clk);
      end
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", 32'(imem_addr), 32'(exp_pc % 32));
      if (full) chk("fetch_busy", 32'(busy), 32'd1);
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("dec_ir", ir, w);
      chk("dec_req", 32'(imem_req), 32'd0);
      if (full) begin
         chk("dec_rd", 32'(rf_rd), 32'(w[11:7]));
         chk("dec_rs1", 32'(rf_rs1), 32'(w[19:15]));
         chk("dec_rs2", 32'(rf_rs2), 32'(w[24:20]));
      end
      @(negedge clk);
      if (!legal) begin
         chk("ill_halted", 32'(halted), 32'd1);
         chk("ill_sticky", 32'(illegal), 32'd1);
         chk("ill_pc", 32'(pc), 32'(exp_pc % 32));
         chk("ill_ret", 32'(retired), 32'(exp_ret % 65536));
         chk("ill_busy", 32'(busy), 32'd0);
         return;
      end
      chk("exec_op", 32'(alu_op), 32'(op));
      if (full) chk("exec_we", 32'(rf_we), 32'd0);
      @(negedge clk);
      chk("wb_we", 32'(rf_we), 32'(we));
      if (full) chk("wb_pc", 32'(pc), 32'(exp_pc % 32));
      exp_pc++;
      exp_ret++;
      @(negedge clk);
      chk("ret_pc", 32'(pc), 32'(exp_pc % 32));
      chk("ret_cnt", 32'(retired), 32'(exp_ret % 65536));
      if (full) begin
         chk("ret_we", 32'(rf_we), 32'd0);
         chk("ret_busy", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk_reset_vals("idle");
      run_instr(32'h002081B3, 0, 1'b1, 2'b00, 1'b1, 1'b1);
      run_instr(32'h402081B3, 3, 1'b1, 2'b01, 1'b1, 1'b1);
      run_instr(32'h00208033, 0, 1'b1, 2'b00, 1'b0, 1'b1);
      run_instr(32'h0020F1B3, 1, 1'b1, 2'b10, 1'b1, 1'b1);
      run_instr(32'h0020E1B3, 0, 1'b1, 2'b11, 1'b1, 1'b1);
      while (exp_pc < 31) run_instr(32'h002081B3, 0, 1'b1, 2'b00, 1'b1, 1'b0);
      chk("pre_wrap_pc", 32'(pc), 32'd31);
      run_instr(32'h002081B3, 0, 1'b1, 2'b00, 1'b1, 1'b1);
      chk("wrap_pc", 32'(pc), 32'd0);
      chk("wrap_ret", 32'(retired), 32'd32);
      run_instr(32'h00000013, 0, 1'b0, 2'b00, 1'b0, 1'b1);
      start = 1'b1;
      imem_ack = 1'b1;
      repeat (4) @(negedge clk);
      chk("halt_abs", 32'(halted), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_pc", 32'(pc), 32'd0);
      chk("halt_ret", 32'(retired), 32'd32);
      chk("halt_ir", ir, 32'h00000013);
      start = 1'b0; imem_ack = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_reset_vals("halt_rst");
      exp_pc = 0; exp_ret = 0;
      imem_rdata = 32'h402081B3;
      start = 1'b1;
      @(negedge clk);
      chk("mid_req", 32'(imem_req), 32'd1);
      start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_reset_vals("mid_rst");
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("late_ack_ir", ir, 32'd0);
      chk("late_ack_busy", 32'(busy), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=%0d exp=%0d", 0, 1);
      $fatal(1, "timeout");
   end
endmodule
